// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, PC+4, next-PC selection and the IF/ID latch.
// Redirects (branch/jump), stalls, flushes and halt are all resolved here.
module if_fetch_stage #(
   parameter int               NBITS    = 32,
   parameter logic [NBITS-1:0] PC_RESET = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_stall,
   input  logic             i_pc_src,
   input  logic [NBITS-1:0] i_mux_sumador_branch,
   input  logic             i_jump,
   input  logic [NBITS-1:0] i_jump_addr,
   input  logic             i_halt,
   input  logic [NBITS-1:0] i_instruction,
   output logic [NBITS-1:0] o_pc,
   output logic [NBITS-1:0] o_sumador_pc4,
   output logic [NBITS-1:0] o_instruction,
   output logic             o_valid,
   output logic             o_halted,
   output logic [31:0]      o_fetch_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic [1:0]       state;
   logic [NBITS-1:0] pc_plus4;

   // Wraps modulo 2^NBITS; no carry is kept.
   assign pc_plus4 = o_pc + NBITS'(4);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= ST_IDLE;
         o_pc          <= PC_RESET;
         o_sumador_pc4 <= '0;
         o_instruction <= '0;
         o_valid       <= 1'b0;
         o_halted      <= 1'b0;
         o_fetch_count <= '0;
      end else if (i_enable) begin
         case (state)
            ST_IDLE: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (i_halt) begin
                  state         <= ST_HALTED;
                  o_halted      <= 1'b1;
                  o_instruction <= '0;
                  o_valid       <= 1'b0;
               end else if (!i_stall) begin
                  // Redirects flush IF/ID but keep the last latched PC+4.
                  if (i_pc_src) begin
                     o_pc          <= i_mux_sumador_branch;
                     o_instruction <= '0;
                     o_valid       <= 1'b0;
                  end else if (i_jump) begin
                     o_pc          <= i_jump_addr;
                     o_instruction <= '0;
                     o_valid       <= 1'b0;
                  end else begin
                     o_pc          <= pc_plus4;
                     o_sumador_pc4 <= pc_plus4;
                     o_instruction <= i_instruction;
                     o_valid       <= 1'b1;
                     o_fetch_count <= o_fetch_count + 32'd1;
                  end
               end
            end
            ST_HALTED: begin
               o_valid <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table, hand-written corner
// sequences, a wrap-around instance and randomized traffic against a reference model.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, stall, src, jmp, halt;
   logic [31:0] br, ja, instr;
   logic [31:0] pc, pc4, inst_q, cnt;
   logic        valid, halted;

   logic        w_rst, w_en;
   logic        w_zero = 1'b0;
   logic [31:0] w_zero32 = 32'h0;
   logic [31:0] w_instr, w_pc, w_pc4, w_inst_q, w_cnt;
   logic        w_valid, w_halted;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return 32'h1000_0000 | a;
   endfunction

   assign instr   = imem(pc);
   assign w_instr = imem(w_pc);

   if_fetch_stage #(.NBITS(32), .PC_RESET(32'h0)) dut (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall), .i_pc_src(src),
      .i_mux_sumador_branch(br), .i_jump(jmp), .i_jump_addr(ja), .i_halt(halt),
      .i_instruction(instr), .o_pc(pc), .o_sumador_pc4(pc4), .o_instruction(inst_q),
      .o_valid(valid), .o_halted(halted), .o_fetch_count(cnt)
   );

   if_fetch_stage #(.NBITS(32), .PC_RESET(32'hFFFF_FFF8)) u_wrap (
      .i_clk(clk), .i_reset(w_rst), .i_enable(w_en), .i_stall(w_zero), .i_pc_src(w_zero),
      .i_mux_sumador_branch(w_zero32), .i_jump(w_zero), .i_jump_addr(w_zero32), .i_halt(w_zero),
      .i_instruction(w_instr), .o_pc(w_pc), .o_sumador_pc4(w_pc4), .o_instruction(w_inst_q),
      .o_valid(w_valid), .o_halted(w_halted), .o_fetch_count(w_cnt)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                            input logic [31:0] e_instr, input logic [31:0] e_pc4,
                            input logic e_halted, input logic [31:0] e_cnt);
      check({tag, ".pc"},     pc,     e_pc);
      check({tag, ".valid"},  {31'b0, valid},  {31'b0, e_valid});
      check({tag, ".instr"},  inst_q, e_instr);
      check({tag, ".pc4"},    pc4,    e_pc4);
      check({tag, ".halted"}, {31'b0, halted}, {31'b0, e_halted});
      check({tag, ".count"},  cnt,    e_cnt);
   endtask

   task automatic drive(input logic r, input logic e, input logic s, input logic ps,
                        input logic [31:0] b, input logic j, input logic [31:0] jad,
                        input logic h);
      rst = r; en = e; stall = s; src = ps; br = b; jmp = j; ja = jad; halt = h;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst, en, stall, src;
      logic [31:0] br;
      logic        jmp;
      logic [31:0] ja;
      logic        halt;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [31:0] e_instr, e_pc4;
      logic        e_halted;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic e, input logic s, input logic ps,
                      input logic [31:0] b, input logic j, input logic [31:0] jad, input logic h,
                      input logic [31:0] epc, input logic ev, input logic [31:0] ei,
                      input logic [31:0] ep4, input logic eh, input logic [31:0] ec);
      vec_t v;
      v.rst = r; v.en = e; v.stall = s; v.src = ps; v.br = b; v.jmp = j; v.ja = jad; v.halt = h;
      v.e_pc = epc; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep4; v.e_halted = eh; v.e_cnt = ec;
      vecs.push_back(v);
   endtask

   // Reference model: the stage described as a mode plus architectural values.
   typedef enum {M_IDLE, M_RUN, M_HALTED} mode_e;
   typedef struct {
      mode_e       mode;
      logic [31:0] pc, pc4, instr, cnt;
      logic        valid;
   } model_t;

   function automatic model_t model_next(input model_t m, input logic r, input logic e,
                                         input logic s, input logic ps, input logic [31:0] b,
                                         input logic j, input logic [31:0] jad, input logic h);
      model_t n = m;
      if (r) begin
         n.mode = M_IDLE; n.pc = 0; n.pc4 = 0; n.instr = 0; n.valid = 0; n.cnt = 0;
      end else if (!e || m.mode == M_HALTED) begin
         n = m;
      end else if (m.mode == M_IDLE) begin
         n.mode = M_RUN;
      end else if (h) begin
         n.mode = M_HALTED; n.instr = 0; n.valid = 0;
      end else if (s) begin
         n = m;
      end else if (ps || j) begin
         n.pc = ps ? b : jad; n.instr = 0; n.valid = 0;
      end else begin
         n.instr = imem(m.pc);
         n.pc4   = m.pc + 32'd4;
         n.pc    = m.pc + 32'd4;
         n.valid = 1;
         n.cnt   = m.cnt + 1;
      end
      return n;
   endfunction

   initial begin
      model_t m;
      logic [31:0] hold_pc, hold_cnt;
      logic r, e, s, ps, j, h;
      logic [31:0] b, jad;

      drive(0, 0, 0, 0, 0, 0, 0, 0);
      w_rst = 1'b0; w_en = 1'b0;

      // ---------------- directed vector table ----------------
      add(1,0,0,0,0,0,0,0,   32'h0,   0, 32'h0,         32'h0,   0, 0);
      add(0,1,0,0,0,0,0,0,   32'h0,   0, 32'h0,         32'h0,   0, 0);
      add(0,1,0,0,0,0,0,0,   32'h4,   1, 32'h1000_0000, 32'h4,   0, 1);
      add(0,1,0,0,0,0,0,0,   32'h8,   1, 32'h1000_0004, 32'h8,   0, 2);
      add(0,1,0,0,0,0,0,0,   32'hC,   1, 32'h1000_0008, 32'hC,   0, 3);
      add(0,1,0,0,0,0,0,0,   32'h10,  1, 32'h1000_000C, 32'h10,  0, 4);
      add(0,1,0,1,32'h40,0,0,0, 32'h40, 0, 32'h0,         32'h10,  0, 4);
      add(0,1,0,0,0,0,0,0,   32'h44,  1, 32'h1000_0040, 32'h44,  0, 5);
      add(0,1,0,1,32'h80,1,32'h200,0, 32'h80, 0, 32'h0,   32'h44,  0, 5);
      add(0,1,0,0,0,0,0,0,   32'h84,  1, 32'h1000_0080, 32'h84,  0, 6);
      add(0,1,0,0,0,1,32'h200,0, 32'h200, 0, 32'h0,       32'h84,  0, 6);
      add(0,1,0,0,0,0,0,0,   32'h204, 1, 32'h1000_0200, 32'h204, 0, 7);
      add(0,0,0,1,32'h999,0,0,0, 32'h204, 1, 32'h1000_0200, 32'h204, 0, 7);
      add(0,1,0,1,32'h40,0,0,1, 32'h204, 0, 32'h0,       32'h204, 1, 7);
      add(0,1,0,1,32'h40,0,0,0, 32'h204, 0, 32'h0,       32'h204, 1, 7);
      add(1,1,0,0,0,0,0,0,   32'h0,   0, 32'h0,         32'h0,   0, 0);
      add(0,0,0,0,0,0,0,0,   32'h0,   0, 32'h0,         32'h0,   0, 0);
      add(0,1,0,0,0,0,0,0,   32'h0,   0, 32'h0,         32'h0,   0, 0);
      add(0,1,0,0,0,0,0,0,   32'h4,   1, 32'h1000_0000, 32'h4,   0, 1);

      #1;
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].stall, vecs[i].src,
               vecs[i].br, vecs[i].jmp, vecs[i].ja, vecs[i].halt);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_instr,
                   vecs[i].e_pc4, vecs[i].e_halted, vecs[i].e_cnt);
      end

      // ---------------- stall with pending branch ----------------
      drive(0, 1, 1, 1, 32'h300, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_all($sformatf("stall%0d", k), 32'h4, 1, 32'h1000_0000, 32'h4, 0, 1);
      end
      drive(0, 1, 0, 1, 32'h300, 0, 0, 0);
      step();
      check_all("stall_redirect", 32'h300, 0, 32'h0, 32'h4, 0, 1);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      step();
      check_all("stall_target", 32'h304, 1, 32'h1000_0300, 32'h304, 0, 2);

      // ---------------- enable low freezes everything ----------------
      hold_pc = pc; hold_cnt = cnt;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("en_off%0d.pc", k), pc, 32'h304);
         check($sformatf("en_off%0d.count", k), cnt, 32'd2);
      end

      // ---------------- PC wrap-around instance ----------------
      w_rst = 1'b1; w_en = 1'b0;
      step();
      check("wrap.reset_pc", w_pc, 32'hFFFF_FFF8);
      check("wrap.reset_valid", {31'b0, w_valid}, 32'h0);
      w_rst = 1'b0; w_en = 1'b1;
      step();
      check("wrap.idle_pc", w_pc, 32'hFFFF_FFF8);
      step();
      check("wrap.pc1", w_pc, 32'hFFFF_FFFC);
      check("wrap.pc4_1", w_pc4, 32'hFFFF_FFFC);
      check("wrap.instr1", w_inst_q, 32'hFFFF_FFF8);
      step();
      check("wrap.pc2", w_pc, 32'h0000_0000);
      check("wrap.pc4_2", w_pc4, 32'h0000_0000);
      check("wrap.instr2", w_inst_q, 32'hFFFF_FFFC);
      step();
      check("wrap.pc3", w_pc, 32'h0000_0004);
      check("wrap.count", w_cnt, 32'd3);
      w_en = 1'b0;

      // ---------------- randomized traffic vs model ----------------
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      step();
      m = '{mode: M_IDLE, pc: 0, pc4: 0, instr: 0, cnt: 0, valid: 0};
      for (int c = 0; c < 600; c++) begin
         r   = ($urandom_range(0, 49) == 0);
         e   = ($urandom_range(0, 7) != 0);
         s   = ($urandom_range(0, 3) == 0);
         ps  = ($urandom_range(0, 7) == 0);
         j   = ($urandom_range(0, 7) == 0);
         h   = ($urandom_range(0, 59) == 0);
         b   = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00};
         jad = {$urandom_range(0, 1023), 2'b00};
         drive(r, e, s, ps, b, j, jad, h);
         m = model_next(m, r, e, s, ps, b, j, jad, h);
         step();
         check_all($sformatf("rnd%0d", c), m.pc, m.valid, m.instr, m.pc4,
                   m.mode == M_HALTED, m.cnt);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
